// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// mult/multu completes after MUL_LAT cycles; div/divu is restoring, one quotient bit per cycle.
module md_unit #(
    parameter int MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] F_MTHI = 3'd1;
    localparam logic [2:0] F_MTLO = 3'd2;
    localparam logic [2:0] F_MULT = 3'd3;
    localparam logic [2:0] F_DIV  = 3'd4;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    // opa_q: multiplicand, or dividend magnitude shifting into the quotient
    logic [31:0] opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
    logic        sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic signed [65:0] mul_a, mul_b, prod;
    logic [32:0] rem_sh, diff;
    logic        ge;
    logic [31:0] rem_nx, quo_nx, q_fin, r_fin;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        mul_a  = {{34{sgn_q & opa_q[31]}}, opa_q};
        mul_b  = {{34{sgn_q & opb_q[31]}}, opb_q};
        prod   = mul_a * mul_b;
        rem_sh = {rem_q, opa_q[31]};
        diff   = rem_sh - {1'b0, opb_q};
        ge     = ~diff[32];
        rem_nx = ge ? diff[31:0] : rem_sh[31:0];
        quo_nx = {opa_q[30:0], ge};
        q_fin  = qneg_q ? (32'd0 - quo_nx) : quo_nx;
        r_fin  = rneg_q ? (32'd0 - rem_nx) : rem_nx;
        a_neg  = md_sign & src_a[31];
        b_neg  = md_sign & src_b[31];
        mag_a  = a_neg ? (32'd0 - src_a) : src_a;
        mag_b  = b_neg ? (32'd0 - src_b) : src_b;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    case (md_func)
                        F_MTHI: hi_d = src_a;
                        F_MTLO: lo_d = src_a;
                        F_MULT: begin
                            state_d = S_MUL;
                            cnt_d   = 5'(MUL_LAT - 1);
                            opa_d   = src_a;
                            opb_d   = src_b;
                            sgn_d   = md_sign;
                        end
                        F_DIV: begin
                            state_d = S_DIV;
                            cnt_d   = 5'd31;
                            opa_d   = mag_a;
                            opb_d   = mag_b;
                            rem_d   = 32'd0;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            dz_d    = (src_b == 32'd0);
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else if (cnt_q == 5'd0) begin
                    state_d = S_IDLE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    opa_d = quo_nx;
                    rem_d = rem_nx;
                    if (cnt_q == 5'd0) begin
                        state_d = S_IDLE;
                        // divide by zero burns the full latency but never writes HI/LO
                        if (!dz_q) begin
                            hi_d = r_fin;
                            lo_d = q_fin;
                        end
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            rem_q   <= 32'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random mult/div against a longint reference model.
module tb_md_unit;
    localparam int MUL_LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_func;
    logic        md_sign;
    logic [31:0] src_a, src_b;
    logic        cancel;
    logic [31:0] hi, lo;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi, m_lo;

    md_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(rst_n), .start(start), .md_func(md_func), .md_sign(md_sign),
        .src_a(src_a), .src_b(src_b), .cancel(cancel), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted op, from plain arithmetic.
    task automatic model(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (f)
            3'd1: m_hi = a;
            3'd2: m_lo = a;
            3'd3: begin
                if (s) p = 64'(longint'($signed(a)) * longint'($signed(b)));
                else   p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd4: if (b != 0) begin
                if (s) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; md_func = f; md_sign = s; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; md_func = 3'd0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input int lat);
        logic [31:0] oh, ol;
        int n;
        bit held;
        oh = hi; ol = lo;
        model(f, s, a, b);
        issue(f, s, a, b);
        n = 0; held = 1'b1;
        while (busy && n < 100) begin
            if (hi !== oh || lo !== ol) held = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(lat));
        if (lat > 0) chk({tag, "_held_until_done"}, {31'd0, held}, 32'd1);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        logic [31:0] oh, ol, a, b;
        logic [2:0] f;
        logic s;
        int n;
        rst_n = 1'b0; start = 1'b0; md_func = 3'd0; md_sign = 1'b0;
        src_a = 32'd0; src_b = 32'd0; cancel = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("mthi", 3'd1, 1'b0, 32'h12345678, 32'd0, 0);
        run_op("mtlo", 3'd2, 1'b0, 32'h9ABCDEF0, 32'd0, 0);
        chk("mthi_const", hi, 32'h12345678);
        chk("mtlo_const", lo, 32'h9ABCDEF0);

        run_op("mult_s", 3'd3, 1'b1, 32'hFFFFFFFE, 32'd3, MUL_LAT);
        chk("mult_s_const_hi", hi, 32'hFFFFFFFF);
        chk("mult_s_const_lo", lo, 32'hFFFFFFFA);
        run_op("multu", 3'd3, 1'b0, 32'hFFFFFFFE, 32'd3, MUL_LAT);
        chk("multu_const_hi", hi, 32'h00000002);

        run_op("div_s", 3'd4, 1'b1, 32'hFFFFFFF9, 32'd2, 32);
        chk("div_s_const_lo", lo, 32'hFFFFFFFD);
        chk("div_s_const_hi", hi, 32'hFFFFFFFF);
        run_op("divu", 3'd4, 1'b0, 32'd100, 32'd7, 32);
        chk("divu_const_lo", lo, 32'd14);
        chk("divu_const_hi", hi, 32'd2);
        run_op("div_ovf", 3'd4, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32);
        chk("div_ovf_const_lo", lo, 32'h80000000);
        chk("div_ovf_const_hi", hi, 32'h0);

        run_op("pre_hi", 3'd1, 1'b0, 32'hAAAA, 32'd0, 0);
        run_op("pre_lo", 3'd2, 1'b0, 32'h5555, 32'd0, 0);
        run_op("div0", 3'd4, 1'b1, 32'd1234, 32'd0, 32);
        chk("div0_const_hi", hi, 32'hAAAA);
        chk("div0_const_lo", lo, 32'h5555);

        // cancel at cycle 10 of a divide
        oh = hi; ol = lo;
        issue(3'd4, 1'b0, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        chk("cancel_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk); cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        chk("cancel_busy_after", {31'd0, busy}, 32'd0);
        chk("cancel_hi", hi, oh);
        chk("cancel_lo", lo, ol);

        // start with cancel high in IDLE is ignored
        @(negedge clk); start = 1'b1; md_func = 3'd1; src_a = 32'hFFFF; cancel = 1'b1;
        @(posedge clk); #1; start = 1'b0; md_func = 3'd0; cancel = 1'b0;
        chk("start_cancel_hi", hi, oh);

        // start while busy is ignored; original result still arrives at E0+32
        model(3'd4, 1'b1, 32'hFFFFFFF9, 32'd2);
        issue(3'd4, 1'b1, 32'hFFFFFFF9, 32'd2);
        n = 0;
        repeat (4) begin @(posedge clk); #1; n++; end
        @(negedge clk); start = 1'b1; md_func = 3'd2; src_a = 32'hDEADBEEF;
        @(posedge clk); #1; n++;
        start = 1'b0; md_func = 3'd0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        chk("busy_start_cycles", 32'(n), 32'd32);
        chk("busy_start_hi", hi, m_hi);
        chk("busy_start_lo", lo, m_lo);

        // async reset mid-multiply, off the clock edge
        issue(3'd3, 1'b0, 32'h1234, 32'h5678);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_hi", hi, 32'd0);
        chk("areset_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk); rst_n = 1'b1;
        run_op("post_reset_mult", 3'd3, 1'b1, 32'h80000000, 32'h80000000, MUL_LAT);

        for (int i = 0; i < 12; i++) begin
            f = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            if (f == 3'd4 && $urandom_range(0, 5) == 0) b = 32'd0;
            run_op($sformatf("rand%0d", i), f, s, a, b, (f == 3'd3) ? MUL_LAT : 32);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with the architectural HI/LO register pair, located in the EX stage directly downstream of the instruction decoder. It consumes the decoder's MDFunc/MDSign fields together with the forwarded rs/rt operands and executes mult, multu, div, divu, mthi and mtlo. It exposes HI/LO to the EX-stage mfhi/mflo result mux and raises `busy` so that stall detection can hold any dependent MD instruction in ID.

## Interface
Parameters:
- MUL_LAT, 5: busy cycles taken by mult/multu (1..15).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  EX stage holds a valid, non-flushed MD instruction this cycle.
- md_func  in  3  0 none, 1 mthi, 2 mtlo, 3 mult/multu, 4 div/divu, 5–7 treated as none.
- md_sign  in  1  1 selects signed mult/div; ignored for other functions.
- src_a  in  32  rs value: dividend, multiplicand, or mthi/mtlo data.
- src_b  in  32  rt value: divisor or multiplier.
- cancel  in  1  exception flush; aborts an in-flight mult/div.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- busy  out  1  a multiply or divide is in flight.

## Operation
- States: IDLE, MUL, DIV. While in reset: state IDLE, hi = 0, lo = 0, busy = 0, counter = 0.
- Accept: `start` is honoured only in IDLE with `cancel` = 0. If `start` is asserted while busy, or while `cancel` = 1, it is ignored with no state change. Stall detection guarantees this never happens during legal operation; the bench checks that it is ignored.
- mthi/mtlo: at the accept edge, hi (or lo) takes src_a. State stays IDLE and busy stays 0.
- mult/multu: operands are captured at accept. The 64-bit product is {hi, lo}. Signed mode uses two's-complement operands and unsigned mode uses zero extension. The state moves to MUL and the counter loads MUL_LAT-1. The product may be formed by a single multiplier whose result is held in a register; only the update time is observable.
- div/divu: the unit performs a restoring division at one quotient bit per cycle on magnitudes, over 32 iterations. Signed mode applies these rules:
  - operands are converted to magnitudes at accept;
  - the quotient is negated when the operand signs differ;
  - the remainder takes the sign of the dividend;
  - the quotient truncates toward zero;
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Divide by zero: the full 32 cycles still elapse, and hi/lo are left unchanged.
- Completion: hi/lo are written on the edge that returns the state to IDLE. Both registers are written in the same edge.
- cancel: in MUL or DIV, the next edge forces IDLE, leaves hi/lo unchanged, and discards the partial result.
- `start` in IDLE on the same edge as a completion is impossible, because busy is 1 during that cycle, so it is ignored.

## Timing
- Accept edge E0. busy is a registered output: it is 1 from after E0 until the completion edge.
- mult: busy is high for exactly MUL_LAT cycles. hi/lo update at edge E0+MUL_LAT, which is also when busy falls.
- div: busy is high for exactly 32 cycles. hi/lo update at E0+32.
- mthi/mtlo: the new value is visible on hi/lo right after E0. Zero busy cycles.
- An mfhi/mflo in EX during a completion edge sees the old value. Stall detection holds mfhi/mflo, mthi, mtlo, mult and div in ID while busy = 1 or while EX holds a start-eligible mult/div.
- cancel asserted at cycle k of an operation: busy is 0 after the next edge.
- Asynchronous reset mid-operation: immediate IDLE, busy = 0, hi = lo = 0, with no completion write.
- The counter never wraps. A counter value of 0 in MUL or DIV means the final cycle.

## Test plan
- mthi then mtlo: mthi with src_a = 0x12345678, then mtlo with src_a = 0x9ABCDEF0 -> hi = 0x12345678, lo = 0x9ABCDEF0 one edge after each, busy never asserted.
- Signed mult: src_a = 0xFFFFFFFE (-2), src_b = 3 -> busy high 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. Unsigned mult of the same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
- Signed div: -7 / 2 -> after 32 busy cycles, lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). divu 100 / 7 -> lo = 14, hi = 2. Also 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- Divide by zero: preload hi = 0xAAAA, lo = 0x5555, then div by 0 -> busy for 32 cycles, hi/lo unchanged afterward.
- Cancel and ignored start:
  - at cycle 10 of a div, assert cancel -> busy = 0 after the next edge, hi/lo unchanged;
  - start asserted while busy -> ignored, the original result is still delivered at E0+32.
- Async reset: drop reset mid-multiply, off the clock edge -> busy = 0, hi = lo = 0 immediately; release reset -> the next start is accepted normally.
